// File: rtl/irig_b_frame_scheduler.sv
// IRIG-B (B00x) frame scheduler: double-buffered BCD time, PPS-aligned 100-symbol PWM frame.
// Optional straight-binary-seconds field on symbols 80-97 when IRIG_SBS_EN is defined.
module irig_b_frame_scheduler #(
    parameter int TICKS_PER_MS = 50000,
    parameter int SYMBOLS      = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pps,
    input  logic       frame_valid,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic [3:0] days_h_bcd,
    input  logic [3:0] days_m_bcd,
    input  logic [3:0] days_l_bcd,
    input  logic [3:0] year_h_bcd,
    input  logic [3:0] year_l_bcd,
    output logic       irig_out,
    output logic       symbol_strobe,
    output logic [6:0] symbol_idx,
    output logic [1:0] symbol_type,
    output logic       frame_start,
    output logic       busy,
    output logic       time_stale
);
    localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_MS - 1);
    localparam logic [6:0]    LAST_IDX = 7'(SYMBOLS - 1);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    typedef struct packed {
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hour;
        logic [3:0] dh;
        logic [3:0] dm;
        logic [3:0] dl;
        logic [3:0] yh;
        logic [3:0] yl;
    } tset_t;

    state_t          state_q, state_d;
    tset_t           shadow_q, shadow_d, active_q, active_d, in_set;
    logic            loaded_q, loaded_d, pps_q, pps_rise;
    logic [TW-1:0]   tick_q, tick_d;
    logic [3:0]      ms_q, ms_d;
    logic [6:0]      idx_q, idx_d;
    logic            irig_q, irig_d, strobe_q, strobe_d, fstart_q, fstart_d;
    logic            busy_q, busy_d, stale_q, stale_d;
    logic [1:0]      type_q, type_d;
    logic [127:0]    data_bits;
    logic            is_marker;
    logic [3:0]      width_ms;

    // Data bits depend only on the active set; symbol 0 is a marker, so active_q is always current.
    always_comb begin
        data_bits = '0;
        data_bits[4:1]   = active_q.sec[3:0];
        data_bits[8:6]   = active_q.sec[6:4];
        data_bits[13:10] = active_q.min[3:0];
        data_bits[17:15] = active_q.min[6:4];
        data_bits[23:20] = active_q.hour[3:0];
        data_bits[26:25] = active_q.hour[5:4];
        data_bits[33:30] = active_q.dl;
        data_bits[38:35] = active_q.dm;
        data_bits[41:40] = active_q.dh[1:0];
        data_bits[53:50] = active_q.yl;
        data_bits[58:55] = active_q.yh;
`ifdef IRIG_SBS_EN
        begin
            logic [16:0] h_bin, m_bin, s_bin, sbs;
            h_bin = 17'(active_q.hour[7:4]) * 17'd10 + 17'(active_q.hour[3:0]);
            m_bin = 17'(active_q.min[7:4])  * 17'd10 + 17'(active_q.min[3:0]);
            s_bin = 17'(active_q.sec[7:4])  * 17'd10 + 17'(active_q.sec[3:0]);
            sbs   = h_bin * 17'd3600 + m_bin * 17'd60 + s_bin;
            data_bits[88:80] = sbs[8:0];
            data_bits[97:90] = sbs[16:9];
        end
`endif
    end

    logic unused_bits;
    assign unused_bits = ^{active_q.sec[7], active_q.min[7], active_q.hour[7:6], active_q.dh[3:2]};

    always_comb begin
        in_set   = {sec, min, hour, days_h_bcd, days_m_bcd, days_l_bcd, year_h_bcd, year_l_bcd};
        pps_rise = pps & ~pps_q;
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        loaded_d = loaded_q;
        tick_d   = tick_q;
        ms_d     = ms_q;
        idx_d    = idx_q;
        stale_d  = stale_q;
        strobe_d = 1'b0;
        fstart_d = 1'b0;
        if (frame_valid) begin
            shadow_d = in_set;
            loaded_d = 1'b1;
        end
        case (state_q)
            IDLE: if (frame_valid) state_d = ARMED;
            ARMED, RUN: begin
                if (pps_rise) begin
                    // Restart (or resync) at symbol 0; same-cycle load bypasses the shadow.
                    state_d  = RUN;
                    active_d = frame_valid ? in_set : shadow_q;
                    tick_d   = '0;
                    ms_d     = '0;
                    idx_d    = '0;
                    stale_d  = ~(loaded_q | frame_valid);
                    loaded_d = 1'b0;
                    strobe_d = 1'b1;
                    fstart_d = 1'b1;
                end else if (state_q == RUN) begin
                    if (tick_q != TICK_MAX) begin
                        tick_d = tick_q + TW'(1);
                    end else begin
                        tick_d = '0;
                        if (ms_q != 4'd9) begin
                            ms_d = ms_q + 4'd1;
                        end else begin
                            ms_d = '0;
                            if (idx_q == LAST_IDX) begin
                                state_d = ARMED;
                            end else begin
                                idx_d    = idx_q + 7'd1;
                                strobe_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d == RUN);
        is_marker = (idx_d == 7'd0) || ((idx_d % 7'd10) == 7'd9);
        type_d    = !busy_d ? 2'b00 : is_marker ? 2'b10 : {1'b0, data_bits[idx_d]};
        case (type_d)
            2'b10:   width_ms = 4'd8;
            2'b01:   width_ms = 4'd5;
            default: width_ms = 4'd2;
        endcase
        irig_d = busy_d && (ms_d < width_ms);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            loaded_q <= 1'b0;
            pps_q    <= 1'b0;
            tick_q   <= '0;
            ms_q     <= '0;
            idx_q    <= '0;
            irig_q   <= 1'b0;
            strobe_q <= 1'b0;
            fstart_q <= 1'b0;
            busy_q   <= 1'b0;
            stale_q  <= 1'b0;
            type_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            loaded_q <= loaded_d;
            pps_q    <= pps;
            tick_q   <= tick_d;
            ms_q     <= ms_d;
            idx_q    <= idx_d;
            irig_q   <= irig_d;
            strobe_q <= strobe_d;
            fstart_q <= fstart_d;
            busy_q   <= busy_d;
            stale_q  <= stale_d;
            type_q   <= type_d;
        end
    end

    assign irig_out      = irig_q;
    assign symbol_strobe = strobe_q;
    assign symbol_idx    = idx_q;
    assign symbol_type   = type_q;
    assign frame_start   = fstart_q;
    assign busy          = busy_q;
    assign time_stale    = stale_q;
endmodule

// File: tb/tb_irig_b_frame_scheduler.sv
// Directed bench for irig_b_frame_scheduler at TICKS_PER_MS = 4 (one symbol = 40 clks).
module tb_irig_b_frame_scheduler;
    logic       clk = 1'b0, reset = 1'b0, pps = 1'b0, frame_valid = 1'b0;
    logic [7:0] sec = '0, min = '0, hour = '0;
    logic [3:0] dh = '0, dm = '0, dl = '0, yh = '0, yl = '0;
    logic       irig_out, symbol_strobe, frame_start, busy, time_stale;
    logic [6:0] symbol_idx;
    logic [1:0] symbol_type;

    irig_b_frame_scheduler #(.TICKS_PER_MS(4)) dut (
        .clk(clk), .reset(reset), .pps(pps), .frame_valid(frame_valid),
        .sec(sec), .min(min), .hour(hour),
        .days_h_bcd(dh), .days_m_bcd(dm), .days_l_bcd(dl),
        .year_h_bcd(yh), .year_l_bcd(yl),
        .irig_out(irig_out), .symbol_strobe(symbol_strobe), .symbol_idx(symbol_idx),
        .symbol_type(symbol_type), .frame_start(frame_start), .busy(busy), .time_stale(time_stale)
    );

    always #5 clk = ~clk;

    int nvec = 0, nmis = 0;
    logic [1:0] type_log [100];
    int         hi_log   [100];
    int         cur = 0, hc = 0;

    // Passive monitor: per-symbol type at strobe and high-time length in clks.
    always @(negedge clk) begin
        if (symbol_strobe && symbol_idx < 7'd100) begin
            cur = int'(symbol_idx);
            hc  = irig_out ? 1 : 0;
            type_log[cur] = symbol_type;
            hi_log[cur]   = hc;
        end else begin
            if (irig_out) hc++;
            if (cur < 100) hi_log[cur] = hc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input logic [7:0] s, m, h, input logic [3:0] a, b, c, d, e);
        sec = s; min = m; hour = h; dh = a; dm = b; dl = c; yh = d; yl = e;
    endtask

    task automatic load();
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic pulse_pps(input logic with_fv);
        pps = 1'b1;
        frame_valid = with_fv;
        @(negedge clk);
        pps = 1'b0;
        frame_valid = 1'b0;
    endtask

    task automatic wait_sym(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (symbol_strobe && int'(symbol_idx) == target) found = 1'b1;
        end
        chk($sformatf("wait_sym%0d", target), found, 1);
    endtask

    task automatic quiet_window(input string tag, input int n);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy || irig_out) act++;
        end
        chk(tag, act, 0);
    endtask

    logic [1:0] exp_t [100];
    int ones1 [15] = '{2, 3, 6, 8, 12, 15, 16, 21, 25, 30, 31, 36, 40, 52, 56};
    int sbs1  [7]  = '{84, 85, 86, 87, 93, 94, 96};

    initial begin
        int n, fs, w;
        for (int i = 0; i < 100; i++) exp_t[i] = (i == 0 || i % 10 == 9) ? 2'b10 : 2'b00;
        foreach (ones1[i]) exp_t[ones1[i]] = 2'b01;
`ifdef IRIG_SBS_EN
        foreach (sbs1[i]) exp_t[sbs1[i]] = 2'b01;
`endif

        #12;
        chk("rst_irig", irig_out, 0);
        chk("rst_strobe", symbol_strobe, 0);
        chk("rst_idx", symbol_idx, 0);
        chk("rst_type", symbol_type, 0);
        chk("rst_fstart", frame_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stale", time_stale, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(3);

        pulse_pps(1'b0);
        cyc(5);
        pulse_pps(1'b0);
        quiet_window("idle_no_frame", 30);

        set_time(8'h56, 8'h34, 8'h12, 4'd1, 4'd2, 4'd3, 4'd2, 4'd4);
        load();
        quiet_window("armed_quiet", 10);

        pulse_pps(1'b0);
        chk("f1_fstart", frame_start, 1);
        chk("f1_strobe", symbol_strobe, 1);
        chk("f1_busy", busy, 1);
        chk("f1_irig", irig_out, 1);
        chk("f1_idx", symbol_idx, 0);
        chk("f1_type", symbol_type, 2);
        chk("f1_stale", time_stale, 0);
        n = 1; fs = 0;
        for (int i = 0; i < 4200; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (frame_start) fs++;
        end
        chk("f1_len", n, 4000);
        chk("f1_extra_fstart", fs, 0);
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("f1_type%0d", i), type_log[i], exp_t[i]);
            w = (exp_t[i] == 2'b10) ? 32 : (exp_t[i] == 2'b01) ? 20 : 8;
            chk($sformatf("f1_width%0d", i), hi_log[i], w);
        end
        quiet_window("after_frame_armed", 50);

        pulse_pps(1'b0);
        chk("f2_fstart", frame_start, 1);
        chk("f2_stale", time_stale, 1);
        wait_sym(57);
        chk("f2_type6_repeat", type_log[6], 1);
        chk("f2_type40_repeat", type_log[40], 1);

        set_time(8'h03, 8'h02, 8'h01, 4'd0, 4'd4, 4'd5, 4'd2, 4'd5);
        pulse_pps(1'b1);
        chk("early_fstart", frame_start, 1);
        chk("early_idx", symbol_idx, 0);
        chk("early_type", symbol_type, 2);
        chk("early_stale", time_stale, 0);
        wait_sym(5);
        chk("early_sym0_width", hi_log[0], 32);
        chk("new_type1", type_log[1], 1);
        chk("new_type2", type_log[2], 1);
        chk("new_type3", type_log[3], 0);
        wait_sym(30);
        chk("new_type10", type_log[10], 0);
        chk("new_type11", type_log[11], 1);
        chk("new_type20", type_log[20], 1);
        chk("new_type30", symbol_type, 1);
        cyc(3);
        chk("pre_reset_irig", irig_out, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_irig", irig_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_idx", symbol_idx, 0);
        chk("mid_rst_type", symbol_type, 0);
        chk("mid_rst_strobe", symbol_strobe, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        pulse_pps(1'b0);
        quiet_window("shadow_lost_idle", 50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
